// File: rtl/qar_muldiv_if.sv
// Request/response channel between the QAR execute stage and the multi-cycle
// multiply/divide unit.
interface qar_muldiv_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic            busy;

  modport slave (
    input  req_valid, req_op, op_a, op_b, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );

  modport master (
    output req_valid, req_op, op_a, op_b, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );
endinterface

// File: rtl/qar_muldiv.sv
// Multi-cycle shift-add multiplier / restoring divider for the QAR core.
// Define QAR_MULDIV_SIGNED_EN to make opcodes DIV/REM signed; otherwise they are illegal.
module qar_muldiv #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  qar_muldiv_if.slave bus
);

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_MULHU = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_REMU  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_REM   = 3'b101;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              busy_q, busy_d;

  logic              hs_s, mul_op_s, div_op_s, rem_op_s, ovf_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s;
  logic [XLEN:0]     sum_s, trial_s;
  logic [2*XLEN-1:0] step_s;

  assign hs_s = (state_q == S_IDLE) && bus.req_valid && req_ready_q;

`ifdef QAR_MULDIV_SIGNED_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic a_neg_s, b_neg_s, q_neg_q, r_neg_q;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  // Result sign flags captured at the request handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (hs_s) begin
      q_neg_q <= a_neg_s ^ b_neg_s;
      r_neg_q <= a_neg_s;
    end
  end
`endif

  // Request decode: operation class, operand magnitudes and fast-path conditions
  always_comb begin
    mul_op_s = (bus.req_op == OP_MUL) || (bus.req_op == OP_MULHU);
    div_op_s = (bus.req_op == OP_DIVU) || (bus.req_op == OP_REMU);
    rem_op_s = (bus.req_op == OP_REMU);
    mag_a_s  = bus.op_a;
    mag_b_s  = bus.op_b;
    ovf_s    = 1'b0;
`ifdef QAR_MULDIV_SIGNED_EN
    a_neg_s  = 1'b0;
    b_neg_s  = 1'b0;
    if ((bus.req_op == OP_DIV) || (bus.req_op == OP_REM)) begin
      div_op_s = 1'b1;
      rem_op_s = (bus.req_op == OP_REM);
      a_neg_s  = bus.op_a[XLEN-1];
      b_neg_s  = bus.op_b[XLEN-1];
      mag_a_s  = cond_neg(bus.op_a, a_neg_s);
      mag_b_s  = cond_neg(bus.op_b, b_neg_s);
      ovf_s    = (bus.op_a == MOST_NEG) && (bus.op_b == '1);
    end else begin
      a_neg_s  = 1'b0;
      b_neg_s  = 1'b0;
    end
`endif
  end

  // One datapath iteration: shift-add for multiply, trial subtraction for divide
  always_comb begin
    sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    trial_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
    if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
      step_s = acc_q[0] ? {sum_s, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end else if (trial_s[XLEN]) begin
      step_s = {acc_q[2*XLEN-2:XLEN-1], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step_s = {trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          op_d  = bus.req_op;
          cnt_d = '0;
          if (!(mul_op_s || div_op_s)) begin
            res_d   = '0;
            state_d = S_DONE;
          end else if (div_op_s && (bus.op_b == '0)) begin
            res_d   = rem_op_s ? bus.op_a : '1;
            state_d = S_DONE;
          end else if (ovf_s) begin
            res_d   = rem_op_s ? '0 : bus.op_a;
            state_d = S_DONE;
          end else if (mul_op_s) begin
            opnd_d  = bus.op_a;
            acc_d   = {{XLEN{1'b0}}, bus.op_b};
            state_d = S_CALC;
          end else begin
            opnd_d  = mag_b_s;
            acc_d   = {{XLEN{1'b0}}, mag_a_s};
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d = step_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL, OP_DIVU:   res_d = step_s[XLEN-1:0];
            OP_MULHU, OP_REMU: res_d = step_s[2*XLEN-1:XLEN];
`ifdef QAR_MULDIV_SIGNED_EN
            OP_DIV:            res_d = cond_neg(step_s[XLEN-1:0], q_neg_q);
            OP_REM:            res_d = cond_neg(step_s[2*XLEN-1:XLEN], r_neg_q);
`endif
            default:           res_d = '0;
          endcase
        end else begin
          state_d = S_CALC;
        end
      end
      S_DONE: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_q         <= 3'b000;
      opnd_q       <= '0;
      acc_q        <= '0;
      res_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      res_q        <= res_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = res_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_qar_muldiv.sv
// Directed self-checking bench for qar_muldiv (XLEN=32); signed cases follow
// QAR_MULDIV_SIGNED_EN.
module tb_qar_muldiv;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  qar_muldiv_if #(.XLEN(32)) bus ();

  qar_muldiv #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, count edges (handshake edge = 1) until resp_valid, then check.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input bit wiggle, input bit accept);
    int lat;
    int rr_bad;
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_op    = op;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat    = 1;
    rr_bad = 0;
    while (!bus.resp_valid && lat < 100) begin
      if (bus.req_ready !== 1'b0) rr_bad++;
      if (wiggle) begin
        bus.req_valid = lat[0];
        bus.op_a      = $urandom;
        bus.op_b      = $urandom;
        bus.req_op    = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.req_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_ready_low"}, 64'(rr_bad), 64'd0);
    check({tag, "_result"}, 64'(bus.resp_result), 64'(exp_res));
    if (accept) begin
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      check({tag, "_valid_drop"}, 64'(bus.resp_valid), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = 3'b000;
    bus.op_a       = 32'd0;
    bus.op_b       = 32'd0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_result", 64'(bus.resp_result), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);

    // resp_ready while idle must be harmless
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("idle_rr_ready", 64'(bus.req_ready), 64'd1);

    run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 32'h0000_002A, 33, 1'b0, 1'b1);
    run_op("mulhu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, 1'b1);
    run_op("divu_100_7", 3'b010, 32'd100, 32'd7, 32'h0000_000E, 33, 1'b0, 1'b1);
    run_op("remu_100_7", 3'b011, 32'd100, 32'd7, 32'h0000_0002, 33, 1'b0, 1'b1);
    run_op("divu_by0", 3'b010, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 1'b1);
    run_op("remu_by0", 3'b011, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 1'b0, 1'b1);
    run_op("mul_big", 3'b000, 32'h1234_5678, 32'h0000_0100, 32'h3456_7800, 33, 1'b0, 1'b1);

    // Inputs wiggled during CALC, then backpressure
    run_op("divu_1000_10", 3'b010, 32'd1000, 32'd10, 32'h0000_0064, 33, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(bus.resp_valid), 64'd1);
      check("bp_result", 64'(bus.resp_result), 64'h64);
      check("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("bp_release_valid", 64'(bus.resp_valid), 64'd0);
    check("bp_release_ready", 64'(bus.req_ready), 64'd1);
    check("bp_release_busy", 64'(bus.busy), 64'd0);
    check("bp_release_result", 64'(bus.resp_result), 64'h64);

    // Reset at iteration 10 of MUL 3*5
    bus.req_op    = 3'b000;
    bus.op_a      = 32'd3;
    bus.op_b      = 32'd5;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("mid_rst_valid", 64'(bus.resp_valid), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_result", 64'(bus.resp_result), 64'd0);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    check("mid_rst_no_resp", 64'(seen), 64'd0);
    run_op("mul_2x2", 3'b000, 32'd2, 32'd2, 32'h0000_0004, 33, 1'b0, 1'b1);

    run_op("illegal_111", 3'b111, 32'd9, 32'd3, 32'h0000_0000, 1, 1'b0, 1'b1);
`ifdef QAR_MULDIV_SIGNED_EN
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0, 1'b1);
    run_op("rem_m7_2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0, 1'b1);
    run_op("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0, 1'b1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 1'b1);
    run_op("rem_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0, 1'b1);
    run_op("div_by0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 1'b0, 1'b1);
`else
    run_op("op100_illegal", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'h0000_0000, 1, 1'b0, 1'b1);
    run_op("op101_illegal", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h0000_0000, 1, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
